// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports, optional write-to-read bypass
// and a per-register busy scoreboard with a registered population count.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wa_en,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_data,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;
    logic              wa_ok;
    logic              wb_ok;
    logic              rsv_ok;

    // Address 0 is inert for writes, reserves and bypass when hardwired to zero.
    assign wa_ok  = wa_en  && !(ZERO_REG != 0 && wa_addr  == '0);
    assign wb_ok  = wb_en  && !(ZERO_REG != 0 && wb_addr  == '0);
    assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

    // Port B is assigned last so it wins an address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wa_ok) begin
                regs_q[wa_addr] <= wa_data;
            end
            if (wb_ok) begin
                regs_q[wb_addr] <= wb_data;
            end
        end
    end

    // A reserve overrides a release of the same register in the same cycle.
    always_comb begin
        busy_d = busy_q;
        if (wa_ok) begin
            busy_d[wa_addr] = 1'b0;
        end
        if (wb_ok) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = regs_q[addr];
            if (BYPASS != 0) begin
                if (wa_ok && wa_addr == addr) begin
                    data = wa_data;
                end
                if (wb_ok && wb_addr == addr) begin
                    data = wb_data;
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]                  = busy_q[addr];
    end

endmodule
